// File: rtl/sdl_out_stage.sv
`default_nettype none
// ============================================================================
// sdl_out_stage : pixel delay pipeline, colour expansion to 8 bits,
//                 frame marker/counter and input timing monitor
// Revision      : 1.0
// ============================================================================
module sdl_out_stage #(
  parameter int CORDW   = 11,
  parameter int CDEPTH  = 4,
  parameter int DELAY   = 1,
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int ERRW    = 8
) (
  input  logic              clk_pix,
  input  logic              rst_pix,
  input  logic [CORDW-1:0]  sx,
  input  logic [CORDW-1:0]  sy,
  input  logic              de,
  input  logic [CDEPTH-1:0] r,
  input  logic [CDEPTH-1:0] g,
  input  logic [CDEPTH-1:0] b,
  output logic [CORDW-1:0]  sdl_sx,
  output logic [CORDW-1:0]  sdl_sy,
  output logic              sdl_de,
  output logic [7:0]        sdl_r,
  output logic [7:0]        sdl_g,
  output logic [7:0]        sdl_b,
  output logic              frame_start,
  output logic [15:0]       frame_cnt,
  output logic              timing_err,
  output logic [ERRW-1:0]   err_cnt
);

  localparam logic [CORDW-1:0] c_HMAX = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] c_VMAX = CORDW'(V_TOTAL - 1);

  // MSB-first replication of each channel, truncated to 8 bits
  logic [7:0] r_exp, g_exp, b_exp;
  for (genvar i = 0; i < 8; i++) begin : g_expand
    assign r_exp[7-i] = r[CDEPTH-1-(i%CDEPTH)];
    assign g_exp[7-i] = g[CDEPTH-1-(i%CDEPTH)];
    assign b_exp[7-i] = b[CDEPTH-1-(i%CDEPTH)];
  end

  logic [7:0] r_d, g_d, b_d;
  assign r_d = de ? r_exp : 8'h00;
  assign g_d = de ? g_exp : 8'h00;
  assign b_d = de ? b_exp : 8'h00;

  logic [CORDW-1:0] sx_q [DELAY];
  logic [CORDW-1:0] sy_q [DELAY];
  logic             de_q [DELAY];
  logic [7:0]       r_q  [DELAY];
  logic [7:0]       g_q  [DELAY];
  logic [7:0]       b_q  [DELAY];

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      for (int i = 0; i < DELAY; i++) begin
        sx_q[i] <= '0;
        sy_q[i] <= '0;
        de_q[i] <= 1'b0;
        r_q[i]  <= 8'h00;
        g_q[i]  <= 8'h00;
        b_q[i]  <= 8'h00;
      end
    end else begin
      sx_q[0] <= sx;
      sy_q[0] <= sy;
      de_q[0] <= de;
      r_q[0]  <= r_d;
      g_q[0]  <= g_d;
      b_q[0]  <= b_d;
      for (int i = 1; i < DELAY; i++) begin
        sx_q[i] <= sx_q[i-1];
        sy_q[i] <= sy_q[i-1];
        de_q[i] <= de_q[i-1];
        r_q[i]  <= r_q[i-1];
        g_q[i]  <= g_q[i-1];
        b_q[i]  <= b_q[i-1];
      end
    end
  end

  // Data about to enter the final stage, so frame_start lines up with it
  logic [CORDW-1:0] fin_sx_d, fin_sy_d;
  logic             fin_de_d;
  if (DELAY == 1) begin : g_fin_direct
    assign fin_sx_d = sx;
    assign fin_sy_d = sy;
    assign fin_de_d = de;
  end else begin : g_fin_stage
    assign fin_sx_d = sx_q[DELAY-2];
    assign fin_sy_d = sy_q[DELAY-2];
    assign fin_de_d = de_q[DELAY-2];
  end

  logic        fs_d;
  logic        frame_start_q;
  logic [15:0] frame_cnt_q;
  assign fs_d = fin_de_d && (fin_sx_d == '0) && (fin_sy_d == '0);

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'h0000;
    end else begin
      frame_start_q <= fs_d;
      frame_cnt_q   <= frame_cnt_q + 16'(fs_d);
    end
  end

  logic             mon_valid_q;
  logic [CORDW-1:0] prev_sx_q, prev_sy_q;
  logic [CORDW-1:0] exp_sx_d, exp_sy_d;
  logic             mismatch_d;
  logic             timing_err_q;
  logic [ERRW-1:0]  err_cnt_q;

  always_comb begin
    exp_sx_d = prev_sx_q + CORDW'(1);
    exp_sy_d = prev_sy_q;
    if (prev_sx_q == c_HMAX) begin
      exp_sx_d = '0;
      exp_sy_d = (prev_sy_q == c_VMAX) ? '0 : prev_sy_q + CORDW'(1);
    end
    mismatch_d = mon_valid_q &&
                 ((sx != exp_sx_d) || (sy != exp_sy_d) || (sx > c_HMAX) || (sy > c_VMAX));
  end

  // Expectation always re-bases on the actual sample: one jump, one error
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      mon_valid_q  <= 1'b0;
      prev_sx_q    <= '0;
      prev_sy_q    <= '0;
      timing_err_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      mon_valid_q <= 1'b1;
      prev_sx_q   <= sx;
      prev_sy_q   <= sy;
      if (mismatch_d) begin
        timing_err_q <= 1'b1;
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + ERRW'(1);
        end
      end
    end
  end

  assign sdl_sx      = sx_q[DELAY-1];
  assign sdl_sy      = sy_q[DELAY-1];
  assign sdl_de      = de_q[DELAY-1];
  assign sdl_r       = r_q[DELAY-1];
  assign sdl_g       = g_q[DELAY-1];
  assign sdl_b       = b_q[DELAY-1];
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign timing_err  = timing_err_q;
  assign err_cnt     = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sdl_out_stage.sv
`default_nettype none
// ============================================================================
// tb_sdl_out_stage : two parameterisations of sdl_out_stage checked every
//                    cycle against a history-based reference model
// Revision         : 1.0
// ============================================================================
module tb_sdl_out_stage;

  localparam int H = 10;
  localparam int V = 4;

  typedef struct packed {
    logic [10:0] sx;
    logic [10:0] sy;
    logic        de;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } px_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] sx, sy;
  logic        de;
  logic [3:0]  ra, ga, ba;
  logic [4:0]  rb, gb, bb;

  logic [10:0] a_sx, a_sy, b_sx, b_sy;
  logic        a_de, b_de, a_fs, b_fs, a_te, b_te;
  logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
  logic [15:0] a_fc, b_fc;
  logic [7:0]  a_ec;
  logic [1:0]  b_ec;

  int tests = 0;
  int fails = 0;
  int gsx = 0, gsy = 0;

  always #5 clk = ~clk;

  sdl_out_stage #(.CORDW(11), .CDEPTH(4), .DELAY(3), .H_TOTAL(H), .V_TOTAL(V), .ERRW(8)) u_a (
    .clk_pix(clk), .rst_pix(rst), .sx(sx), .sy(sy), .de(de), .r(ra), .g(ga), .b(ba),
    .sdl_sx(a_sx), .sdl_sy(a_sy), .sdl_de(a_de), .sdl_r(a_r), .sdl_g(a_g), .sdl_b(a_b),
    .frame_start(a_fs), .frame_cnt(a_fc), .timing_err(a_te), .err_cnt(a_ec)
  );

  sdl_out_stage #(.CORDW(11), .CDEPTH(5), .DELAY(1), .H_TOTAL(H), .V_TOTAL(V), .ERRW(2)) u_b (
    .clk_pix(clk), .rst_pix(rst), .sx(sx), .sy(sy), .de(de), .r(rb), .g(gb), .b(bb),
    .sdl_sx(b_sx), .sdl_sy(b_sy), .sdl_de(b_de), .sdl_r(b_r), .sdl_g(b_g), .sdl_b(b_b),
    .frame_start(b_fs), .frame_cnt(b_fc), .timing_err(b_te), .err_cnt(b_ec)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Repeat the value as a bit string until at least 8 bits, keep the top 8
  function automatic logic [7:0] expand(input int v, input int c);
    logic [31:0] acc;
    int n;
    acc = 0;
    n = 0;
    while (n < 8) begin
      acc = (acc << c) | v;
      n += c;
    end
    return 8'(acc >> (n - 8));
  endfunction

  function automatic void next_xy(input int x, input int y, output int nx, output int ny);
    int lin;
    if (x < H && y < V) begin
      lin = (y * H + x + 1) % (H * V);
      nx = lin % H;
      ny = lin / H;
    end else if (x == H - 1) begin
      nx = 0;
      ny = y + 1;
    end else begin
      nx = x + 1;
      ny = y;
    end
  endfunction

  // Reference model: history of samples since reset; output = sample DELAY pushes back
  px_t qa[$];
  px_t qb[$];
  int  fca = 0, fcb = 0, merr = 0, psx = 0, psy = 0;
  bit  mval = 0;

  always @(posedge clk) begin
    px_t pa, pb, ea, eb;
    int  ex, ey, eca, ecb;
    if (rst) begin
      qa.delete();
      qb.delete();
      fca = 0;
      fcb = 0;
      merr = 0;
      mval = 0;
    end else begin
      pa.sx = sx; pa.sy = sy; pa.de = de;
      pa.r = de ? expand(ra, 4) : 8'h00;
      pa.g = de ? expand(ga, 4) : 8'h00;
      pa.b = de ? expand(ba, 4) : 8'h00;
      pb = pa;
      pb.r = de ? expand(rb, 5) : 8'h00;
      pb.g = de ? expand(gb, 5) : 8'h00;
      pb.b = de ? expand(bb, 5) : 8'h00;
      qa.push_back(pa);
      qb.push_back(pb);
      if (qa.size() > 16) void'(qa.pop_front());
      if (qb.size() > 16) void'(qb.pop_front());
      if (mval) begin
        next_xy(psx, psy, ex, ey);
        if (int'(sx) != ex || int'(sy) != ey || sx >= H || sy >= V) merr++;
      end
      psx = sx;
      psy = sy;
      mval = 1;
    end
    #1;
    ea = (qa.size() >= 3) ? qa[qa.size()-3] : '0;
    eb = (qb.size() >= 1) ? qb[qb.size()-1] : '0;
    if (ea.de && ea.sx == 0 && ea.sy == 0) fca = (fca + 1) % 65536;
    if (eb.de && eb.sx == 0 && eb.sy == 0) fcb = (fcb + 1) % 65536;
    eca = (merr > 255) ? 255 : merr;
    ecb = (merr > 3) ? 3 : merr;
    chk("a_sx", a_sx, ea.sx);  chk("a_sy", a_sy, ea.sy);  chk("a_de", a_de, ea.de);
    chk("a_r", a_r, ea.r);     chk("a_g", a_g, ea.g);     chk("a_b", a_b, ea.b);
    chk("a_fs", a_fs, ea.de && ea.sx == 0 && ea.sy == 0);
    chk("a_fc", a_fc, fca);    chk("a_te", a_te, merr > 0); chk("a_ec", a_ec, eca);
    chk("b_sx", b_sx, eb.sx);  chk("b_sy", b_sy, eb.sy);  chk("b_de", b_de, eb.de);
    chk("b_r", b_r, eb.r);     chk("b_g", b_g, eb.g);     chk("b_b", b_b, eb.b);
    chk("b_fs", b_fs, eb.de && eb.sx == 0 && eb.sy == 0);
    chk("b_fc", b_fc, fcb);    chk("b_te", b_te, merr > 0); chk("b_ec", b_ec, ecb);
  end

  task automatic drive(input int x, input int y, input bit d);
    @(negedge clk);
    rst = 1'b0;
    sx = 11'(x);
    sy = 11'(y);
    de = d;
    ra = 4'($urandom); ga = 4'($urandom); ba = 4'($urandom);
    rb = 5'($urandom); gb = 5'($urandom); bb = 5'($urandom);
  endtask

  task automatic step_ok();
    drive(gsx, gsy, (gsx < 8) && (gsy < 3));
    next_xy(gsx, gsy, gsx, gsy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic after_edge(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p;
    rst = 1'b1; sx = '0; sy = '0; de = 1'b0;
    ra = '0; ga = '0; ba = '0; rb = '0; gb = '0; bb = '0;
    repeat (2) @(negedge clk);

    // Latency: one sample, visible after exactly three edges on the DELAY=3 instance
    rst = 1'b0; sx = 11'd5; sy = 11'd7; de = 1'b1; ra = 4'h3; ga = 4'h0; ba = 4'h0;
    @(negedge clk);
    sx = '0; sy = '0; de = 1'b0; ra = 4'h0;
    after_edge(1);
    chk("lat_pre_sx", a_sx, 11'd0);
    chk("lat_pre_de", a_de, 1'b0);
    after_edge(1);
    chk("lat_sx", a_sx, 11'd5);
    chk("lat_sy", a_sy, 11'd7);
    chk("lat_r", a_r, 8'h33);

    // Blank forcing, then full-scale with de high
    @(negedge clk);
    de = 1'b0; ra = 4'hF; ga = 4'hF; ba = 4'hF; rb = 5'h1F; gb = 5'h1F; bb = 5'h1F;
    after_edge(3);
    chk("blank_r", a_r, 8'h00);
    chk("blank_de", a_de, 1'b0);
    @(negedge clk);
    de = 1'b1;
    after_edge(3);
    chk("full_r", a_r, 8'hFF);
    chk("full_b", b_b, 8'hFF);

    // Five-bit expansion on the DELAY=1 instance
    @(negedge clk);
    rb = 5'b10110; gb = 5'b00001; bb = 5'b11111;
    after_edge(1);
    chk("exp_r", b_r, 8'hB5);
    chk("exp_g", b_g, 8'h08);
    chk("exp_b", b_b, 8'hFF);

    // Two clean frames
    do_reset();
    gsx = 0; gsy = 0;
    repeat (82) step_ok();
    after_edge(1);
    chk("frm_cnt_a", a_fc, 16'd2);
    chk("frm_cnt_b", b_fc, 16'd3);
    chk("frm_te", a_te, 1'b0);
    chk("frm_ec", a_ec, 8'd0);

    // Single jump sx 3 -> 6 mid-line
    do_reset();
    gsx = 0; gsy = 1;
    repeat (4) step_ok();
    gsx = 6;
    step_ok();
    after_edge(1);
    chk("jump_te", a_te, 1'b1);
    chk("jump_ec", a_ec, 8'd1);
    repeat (15) step_ok();
    after_edge(1);
    chk("jump_ec_hold", a_ec, 8'd1);

    // Five more jumps: two-bit counter saturates
    repeat (5) begin
      step_ok();
      step_ok();
      gsx = (gsx + 3) % H;
    end
    step_ok();
    after_edge(1);
    chk("sat_b_ec", b_ec, 2'd3);
    chk("sat_a_ec", a_ec, 8'd6);

    // Reset mid-line
    do_reset();
    after_edge(1);
    chk("rst_sx", a_sx, 11'd0);
    chk("rst_r", b_r, 8'h00);
    chk("rst_te", a_te, 1'b0);
    chk("rst_ec", a_ec, 8'd0);
    chk("rst_fc", b_fc, 16'd0);
    gsx = 5; gsy = 2;
    repeat (3) step_ok();
    after_edge(1);
    chk("post_rst_te", a_te, 1'b0);

    // Randomised traffic: jumps, out-of-range samples, sporadic resets
    for (int k = 0; k < 3000; k++) begin
      p = $urandom_range(0, 99);
      if (p < 2) begin
        do_reset();
      end else if (p < 7) begin
        gsx = $urandom_range(0, H - 1);
        gsy = $urandom_range(0, V - 1);
        step_ok();
      end else if (p < 9) begin
        drive($urandom_range(H, 30), $urandom_range(0, 6), $urandom_range(0, 1));
      end else begin
        step_ok();
      end
    end
    after_edge(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
